// File: rtl/core_debug_arbiter_if.sv
// Bundles the two master ports and the core_debug command/response port.
// slave = arbiter side, master = environment (masters plus debug module).
interface core_debug_arbiter_if;
  logic        m0_req;
  logic        m0_busy;
  logic [3:0]  m0_command;
  logic [7:0]  m0_target;
  logic [31:0] m0_data;
  logic        m0_resp_valid;
  logic        m0_resp_error;
  logic [31:0] m0_resp_data;

  logic        m1_req;
  logic        m1_busy;
  logic [3:0]  m1_command;
  logic [7:0]  m1_target;
  logic [31:0] m1_data;
  logic        m1_resp_valid;
  logic        m1_resp_error;
  logic [31:0] m1_resp_data;

  logic        dbg_cmd_req;
  logic        dbg_cmd_busy;
  logic [3:0]  dbg_cmd_command;
  logic [7:0]  dbg_cmd_target;
  logic [31:0] dbg_cmd_data;
  logic        dbg_resp_valid;
  logic        dbg_resp_error;
  logic [31:0] dbg_resp_data;

  modport slave (
    input  m0_req, m0_command, m0_target, m0_data,
    output m0_busy, m0_resp_valid, m0_resp_error, m0_resp_data,
    input  m1_req, m1_command, m1_target, m1_data,
    output m1_busy, m1_resp_valid, m1_resp_error, m1_resp_data,
    output dbg_cmd_req, dbg_cmd_command, dbg_cmd_target, dbg_cmd_data,
    input  dbg_cmd_busy, dbg_resp_valid, dbg_resp_error, dbg_resp_data
  );

  modport master (
    output m0_req, m0_command, m0_target, m0_data,
    input  m0_busy, m0_resp_valid, m0_resp_error, m0_resp_data,
    output m1_req, m1_command, m1_target, m1_data,
    input  m1_busy, m1_resp_valid, m1_resp_error, m1_resp_data,
    input  dbg_cmd_req, dbg_cmd_command, dbg_cmd_target, dbg_cmd_data,
    output dbg_cmd_busy, dbg_resp_valid, dbg_resp_error, dbg_resp_data
  );
endinterface

// File: rtl/core_debug_arbiter.sv
// Round-robin sharing of the single core_debug command/response port between two masters.
// Define CORE_DEBUG_ARB_TIMEOUT_EN to recover commands that never receive a response.
module core_debug_arbiter #(
  parameter int unsigned P_TIMEOUT = 1023
) (
  input logic                 iCLOCK,
  input logic                 inRESET,
  core_debug_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RESP} state_t;

  state_t      state;
  logic        last_grant;
  logic        owner;
  logic        m0_accept;
  logic        m1_accept;
  logic        timeout_hit;
  logic        resp_fire;
  logic        resp_error_next;
  logic [31:0] resp_data_next;

  if (P_TIMEOUT == 0 || P_TIMEOUT > 65535) begin : g_bad_timeout
    $error("core_debug_arbiter: P_TIMEOUT must be in 1..65535");
  end

  // On a tie, a master wins only when the other master held the last grant.
  assign bus.m0_busy = (state != IDLE) || (bus.m1_req && !last_grant);
  assign bus.m1_busy = (state != IDLE) || (bus.m0_req && last_grant);
  assign m0_accept   = bus.m0_req && !bus.m0_busy;
  assign m1_accept   = bus.m1_req && !bus.m1_busy;

`ifdef CORE_DEBUG_ARB_TIMEOUT_EN
  logic [15:0] wait_count;

  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      wait_count <= '0;
    end else if (state != WAIT_RESP) begin
      wait_count <= '0;
    end else begin
      wait_count <= wait_count + 16'd1;
    end
  end

  assign timeout_hit = (state == WAIT_RESP) && (wait_count == 16'(P_TIMEOUT - 1));
`else
  assign timeout_hit = 1'b0;
`endif

  assign resp_fire       = (state == WAIT_RESP) && (bus.dbg_resp_valid || timeout_hit);
  // A real response in the expiry cycle takes priority over the timeout error.
  assign resp_error_next = bus.dbg_resp_valid ? bus.dbg_resp_error : 1'b1;
  assign resp_data_next  = bus.dbg_resp_valid ? bus.dbg_resp_data : 32'd0;

  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      state               <= IDLE;
      last_grant          <= 1'b1;
      owner               <= 1'b0;
      bus.dbg_cmd_req     <= 1'b0;
      bus.dbg_cmd_command <= '0;
      bus.dbg_cmd_target  <= '0;
      bus.dbg_cmd_data    <= '0;
      bus.m0_resp_valid   <= 1'b0;
      bus.m0_resp_error   <= 1'b0;
      bus.m0_resp_data    <= '0;
      bus.m1_resp_valid   <= 1'b0;
      bus.m1_resp_error   <= 1'b0;
      bus.m1_resp_data    <= '0;
    end else begin
      bus.m0_resp_valid <= 1'b0;
      bus.m1_resp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (m0_accept || m1_accept) begin
            owner               <= m1_accept;
            last_grant          <= m1_accept;
            bus.dbg_cmd_command <= m1_accept ? bus.m1_command : bus.m0_command;
            bus.dbg_cmd_target  <= m1_accept ? bus.m1_target  : bus.m0_target;
            bus.dbg_cmd_data    <= m1_accept ? bus.m1_data    : bus.m0_data;
            bus.dbg_cmd_req     <= 1'b1;
            state               <= ISSUE;
          end
        end
        ISSUE: begin
          if (!bus.dbg_cmd_busy) begin
            bus.dbg_cmd_req <= 1'b0;
            state           <= WAIT_RESP;
          end
        end
        WAIT_RESP: begin
          if (resp_fire) begin
            if (owner) begin
              bus.m1_resp_valid <= 1'b1;
              bus.m1_resp_error <= resp_error_next;
              bus.m1_resp_data  <= resp_data_next;
            end else begin
              bus.m0_resp_valid <= 1'b1;
              bus.m0_resp_error <= resp_error_next;
              bus.m0_resp_data  <= resp_data_next;
            end
            state <= IDLE;
          end
        end
        default: begin
          bus.dbg_cmd_req <= 1'b0;
          state           <= IDLE;
        end
      endcase
    end
  end

endmodule
